multi_operand_adder: RTL and testbench



---
 rtl/multi_operand_adder.sv | 147 ++++++++++++++
 tb/tb_multi_operand_adder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_operand_adder.sv
// ---------------------------------------------------------------------------
// multi_operand_adder
//
// Sequential adder that sums N_IN unsigned WIDTH-bit operands, one operand
// per clock, behind a start/busy/fin handshake. Operands are captured into an
// internal array when start is accepted, so in_flat may change during the
// operation. An optional running-total mode adds the operands onto the
// previous result.
//
// Build option:
//   MULTI_OPERAND_ADDER_SAT_EN  - when defined, each step saturates at
//                                 2^WIDTH-1. When undefined, the sum wraps.
//                                 ovf reports carry-out in both builds.
//
// Parameters:
//   WIDTH  - operand and sum width in bits (>= 2)
//   N_IN   - operands per operation (>= 2)
//   IDX_W  - operand index width, derived from N_IN (do not override)
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   operation request, sampled only in IDLE
//   acc_mode  in   sampled with start: 0 = sum from zero, 1 = add onto sum
//   in_flat   in   operands; operand k = in_flat[k*WIDTH +: WIDTH]
//   busy      out  high while an operation is in progress
//   sum       out  result register, updated only at the final ACC edge
//   ovf       out  carry-out seen during the last operation
//   fin       out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module multi_operand_adder #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    acc_mode,
    input  logic [N_IN*WIDTH-1:0]   in_flat,
    output logic                    busy,
    output logic [WIDTH-1:0]        sum,
    output logic                    ovf,
    output logic                    fin
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_ops [N_IN];
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_ovf;
    logic             r_busy;
    logic             r_fin;

    logic [WIDTH:0]   w_step;
    logic [WIDTH-1:0] w_next_acc;

    // One accumulation step at WIDTH+1 bits; bit WIDTH is the carry-out.
    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        w_step = {1'b0, r_acc} + {1'b0, r_ops[r_idx]};
`ifdef MULTI_OPERAND_ADDER_SAT_EN
        w_next_acc = w_step[WIDTH] ? '1 : w_step[WIDTH-1:0];
`else
        w_next_acc = w_step[WIDTH-1:0];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            // NOTE: the operand array is deliberately cleared on reset so no
            // stale operand survives; this costs a reset path per flop.
            for (int k = 0; k < N_IN; k++) begin
                r_ops[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_fin <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < N_IN; k++) begin
                            r_ops[k] <= in_flat[k*WIDTH +: WIDTH];
                        end
                        r_idx   <= '0;
                        r_acc   <= acc_mode ? r_sum : '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_ACC;
                    end
                end

                S_ACC: begin
                    r_acc <= w_next_acc;
                    r_idx <= r_idx + 1'b1;
                    if (w_step[WIDTH]) begin
                        r_ovf <= 1'b1;
                    end
                    // The last addition goes straight to sum so sum never
                    // shows a partial total.
                    if (r_idx == LAST_IDX) begin
                        r_sum   <= w_next_acc;
                        r_busy  <= 1'b0;
                        r_fin   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // start is ignored here; no request is queued.
                    r_fin   <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_fin   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign sum  = r_sum;
    assign ovf  = r_ovf;
    assign fin  = r_fin;

endmodule

// File: tb/tb_multi_operand_adder.sv
// ---------------------------------------------------------------------------
// tb_multi_operand_adder
//
// Self-checking bench for multi_operand_adder with WIDTH=16, N_IN=4.
// Expected results are computed by a small reference model and queued when
// an operation is started; they are popped and compared when fin pulses.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours MULTI_OPERAND_ADDER_SAT_EN in the reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_operand_adder;

    localparam int WIDTH = 16;
    localparam int N_IN  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             ovf;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  acc_mode;
    logic [N_IN*WIDTH-1:0] in_flat;
    logic                  busy;
    logic [WIDTH-1:0]      sum;
    logic                  ovf;
    logic                  fin;

    exp_t             sb[$];
    logic [WIDTH-1:0] model_sum;
    int               n_pass;
    int               n_total;

    multi_operand_adder #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .acc_mode (acc_mode),
        .in_flat  (in_flat),
        .busy     (busy),
        .sum      (sum),
        .ovf      (ovf),
        .fin      (fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sum the four operands onto base, one step at a time.
    function automatic exp_t model(input logic [WIDTH-1:0] base,
                                   input logic [N_IN*WIDTH-1:0] flat);
        exp_t             e;
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] a;
        a     = base;
        e.ovf = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            s = {1'b0, a} + {1'b0, flat[k*WIDTH +: WIDTH]};
            if (s[WIDTH]) e.ovf = 1'b1;
`ifdef MULTI_OPERAND_ADDER_SAT_EN
            a = s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
            a = s[WIDTH-1:0];
`endif
        end
        e.sum = a;
        return e;
    endfunction

    // Called at a falling edge in IDLE; returns at the falling edge after
    // the start-sampling edge (first busy cycle).
    task automatic drive_start(input logic [WIDTH-1:0] a, b, c, d,
                               input logic mode, input logic push);
        exp_t e;
        in_flat  = {d, c, b, a};
        acc_mode = mode;
        start    = 1'b1;
        if (push) begin
            e         = model(mode ? model_sum : '0, {d, c, b, a});
            model_sum = e.sum;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for fin; cycle 1 is the caller's current falling edge.
    task automatic wait_fin(output int cyc, output int busy_cnt);
        cyc      = 1;
        busy_cnt = 0;
        while (fin !== 1'b1 && cyc < 50) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        if (fin !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        acc_mode = 1'b0;
        in_flat  = '1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if ({busy, fin, ovf, sum} !== {1'b0, 1'b0, 1'b0, 16'h0000})
                $display("FAIL reset_idle cyc%0d: busy=%b fin=%b ovf=%b sum=%h, want 0 0 0 0000",
                         i, busy, fin, ovf, sum);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        int   cyc, bcnt;
        exp_t e;
        drive_start(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b1);
        wait_fin(cyc, bcnt);
        n_total++;
        if (cyc !== 5) $display("FAIL basic_latency: got %0d want 5", cyc);
        else n_pass++;
        n_total++;
        if (bcnt !== 4) $display("FAIL basic_busy_cycles: got %0d want 4", bcnt);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL basic_busy_at_fin: got %b want 0", busy);
        else n_pass++;
        e = sb.pop_front();
        n_total++;
        if (sum !== e.sum || ovf !== e.ovf)
            $display("FAIL basic_result: sum=%h ovf=%b want sum=%h ovf=%b", sum, ovf, e.sum, e.ovf);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (fin !== 1'b0 || sum !== e.sum)
            $display("FAIL basic_fin_one_cycle: fin=%b sum=%h want fin=0 sum=%h", fin, sum, e.sum);
        else n_pass++;
    endtask

    task automatic test_running_total();
        int   cyc, bcnt;
        exp_t e;
        drive_start(16'h0010, 16'h0010, 16'h0010, 16'h0010, 1'b1, 1'b1);
        in_flat = {4{16'hFFFF}};   // must not disturb the captured operands
        @(negedge clk);
        n_total++;
        if (sum !== 16'd10) $display("FAIL running_no_partial: sum=%h want 000a", sum);
        else n_pass++;
        wait_fin(cyc, bcnt);
        n_total++;
        if (cyc < 0) $display("FAIL running_timeout: no fin");
        else n_pass++;
        e = sb.pop_front();
        n_total++;
        if (sum !== e.sum || ovf !== e.ovf || sum !== 16'h004A)
            $display("FAIL running_result: sum=%h ovf=%b want sum=%h ovf=%b", sum, ovf, e.sum, e.ovf);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int   cyc, bcnt;
        exp_t e;
        drive_start(16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b1);
        wait_fin(cyc, bcnt);
        e = sb.pop_front();
        n_total++;
        if (cyc < 0 || sum !== e.sum || ovf !== e.ovf)
            $display("FAIL overflow_result: cyc=%0d sum=%h ovf=%b want sum=%h ovf=1",
                     cyc, sum, ovf, e.sum);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (ovf !== 1'b1) $display("FAIL overflow_held: ovf=%b want 1", ovf);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   c, nfin, last;
        in_flat  = {16'd4, 16'd3, 16'd2, 16'd1};
        acc_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e         = model(model_sum, in_flat);
            model_sum = e.sum;
            sb.push_back(e);
        end
        start = 1'b1;
        c     = 0;
        nfin  = 0;
        last  = 0;
        while (nfin < 3 && c < 40) begin
            @(negedge clk);
            c++;
            if (fin === 1'b1) begin
                n_total++;
                if (c - last !== ((nfin == 0) ? 5 : 6))
                    $display("FAIL b2b_spacing%0d: got %0d want %0d", nfin, c - last, (nfin == 0) ? 5 : 6);
                else n_pass++;
                e = sb.pop_front();
                n_total++;
                if (sum !== e.sum || ovf !== e.ovf)
                    $display("FAIL b2b_result%0d: sum=%h ovf=%b want sum=%h ovf=%b",
                             nfin, sum, ovf, e.sum, e.ovf);
                else n_pass++;
                last = c;
                nfin++;
            end
        end
        start = 1'b0;
        n_total++;
        if (nfin !== 3) $display("FAIL b2b_count: got %0d fins want 3", nfin);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int   cyc, bcnt, nbusy;
        exp_t e;
        drive_start(16'd5, 16'd6, 16'd7, 16'd8, 1'b1, 1'b1);
        in_flat = {4{16'h0100}};
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_fin(cyc, bcnt);
        e = sb.pop_front();
        n_total++;
        if (cyc < 0 || sum !== e.sum || ovf !== e.ovf)
            $display("FAIL ignore_result: cyc=%0d sum=%h ovf=%b want sum=%h ovf=%b",
                     cyc, sum, ovf, e.sum, e.ovf);
        else n_pass++;
        start = 1'b1;               // lands in DONE: must be dropped
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy === 1'b1 || fin === 1'b1) nbusy++;
        end
        n_total++;
        if (nbusy !== 0) $display("FAIL ignore_no_queue: %0d active cycles want 0", nbusy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int   cyc, bcnt, nfin;
        exp_t e;
        drive_start(16'h1234, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);
        @(negedge clk);
        rst   = 1'b1;               // sampled on the second ACC edge
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        n_total++;
        if ({busy, fin, ovf, sum} !== {1'b0, 1'b0, 1'b0, 16'h0000})
            $display("FAIL reset_mid_state: busy=%b fin=%b ovf=%b sum=%h want 0 0 0 0000",
                     busy, fin, ovf, sum);
        else n_pass++;
        nfin = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fin === 1'b1 || busy === 1'b1) nfin++;
        end
        n_total++;
        if (nfin !== 0) $display("FAIL reset_mid_no_fin: %0d active cycles want 0", nfin);
        else n_pass++;
        model_sum = '0;
        drive_start(16'd5, 16'd5, 16'd5, 16'd5, 1'b1, 1'b1);
        wait_fin(cyc, bcnt);
        e = sb.pop_front();
        n_total++;
        if (cyc !== 5 || sum !== e.sum || sum !== 16'd20 || ovf !== 1'b0)
            $display("FAIL reset_mid_fresh: cyc=%0d sum=%h ovf=%b want cyc=5 sum=0014 ovf=0",
                     cyc, sum, ovf);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        model_sum = '0;
        rst       = 1'b1;
        start     = 1'b0;
        acc_mode  = 1'b0;
        in_flat   = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_running_total();
        test_overflow();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        n_total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
